// File: rtl/mdu_pkg.sv
// Shared definitions for the RV64M multiply/divide front-end: funct3 codes,
// mac one-hot select positions, FSM states and default latencies.
package mdu_pkg;

  localparam int MUL_LAT_DEF = 2;
  localparam int DIV_LAT_DEF = 4;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Bit positions inside mac_sel; mulhu/mulhsu order differs from funct3 order
  localparam int SEL_MUL    = 0;
  localparam int SEL_MULH   = 1;
  localparam int SEL_MULHU  = 2;
  localparam int SEL_MULHSU = 3;
  localparam int SEL_DIV    = 4;
  localparam int SEL_DIVU   = 5;
  localparam int SEL_REM    = 6;
  localparam int SEL_REMU   = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [7:0] sel_onehot(input logic [2:0] funct3);
    logic [7:0] sel;
    sel = 8'd0;
    case (funct3)
      F3_MUL:    sel[SEL_MUL]    = 1'b1;
      F3_MULH:   sel[SEL_MULH]   = 1'b1;
      F3_MULHSU: sel[SEL_MULHSU] = 1'b1;
      F3_MULHU:  sel[SEL_MULHU]  = 1'b1;
      F3_DIV:    sel[SEL_DIV]    = 1'b1;
      F3_DIVU:   sel[SEL_DIVU]   = 1'b1;
      F3_REM:    sel[SEL_REM]    = 1'b1;
      F3_REMU:   sel[SEL_REMU]   = 1'b1;
      default:   sel             = 8'd0;
    endcase
    return sel;
  endfunction

  // Only mulw and the div/rem family have word forms
  function automatic logic word_legal(input logic [2:0] funct3);
    return (funct3 == F3_MUL) || funct3[2];
  endfunction

endpackage

// File: rtl/mdu_opnd_ext.sv
// Word-variant handling: 32-bit operand extension on the request side and
// sign-extension of the low result word on the response side.
module mdu_opnd_ext
  import mdu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        word,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  output logic        word_eff,
  output logic [63:0] opnd1,
  output logic [63:0] opnd2,
  input  logic        res_word,
  input  logic [63:0] res_raw,
  output logic [63:0] res_ext
);

  // Operand preparation; funct3[0] selects the unsigned divide flavours
  always_comb begin
    word_eff = word & word_legal(funct3);
    opnd1    = src1;
    opnd2    = src2;
    if (word_eff && funct3[2]) begin
      if (funct3[0]) begin
        opnd1 = {32'd0, src1[31:0]};
        opnd2 = {32'd0, src2[31:0]};
      end else begin
        opnd1 = {{32{src1[31]}}, src1[31:0]};
        opnd2 = {{32{src2[31]}}, src2[31:0]};
      end
    end else begin
      opnd1 = src1;
      opnd2 = src2;
    end
  end

  // Result sign-extension for word ops
  always_comb begin
    res_ext = res_raw;
    if (res_word) begin
      res_ext = {{32{res_raw[31]}}, res_raw[31:0]};
    end else begin
      res_ext = res_raw;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Sequential front-end for the RV64M mac: accepts one op per handshake, holds
// the one-hot select and operands for a fixed latency, then returns the result.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [4:0]      in_rd,
  output logic [7:0]      mac_sel,
  output logic [XLEN-1:0] mac_src1,
  output logic [XLEN-1:0] mac_src2,
  input  logic [XLEN-1:0] mac_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  state_e            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              word_r;
  logic [4:0]        rd_r;

  logic              accept_s;
  logic              word_eff_s;
  logic [XLEN-1:0]   opnd1_s;
  logic [XLEN-1:0]   opnd2_s;
  logic [XLEN-1:0]   res_ext_s;

  mdu_opnd_ext u_ext (
    .funct3   (in_funct3),
    .word     (in_word),
    .src1     (in_src1),
    .src2     (in_src2),
    .word_eff (word_eff_s),
    .opnd1    (opnd1_s),
    .opnd2    (opnd2_s),
    .res_word (word_r),
    .res_raw  (mac_result),
    .res_ext  (res_ext_s)
  );

  // Accept in IDLE, or in DONE when the result leaves this cycle; never during flush
  always_comb begin
    in_ready = 1'b0;
    if (flush) begin
      in_ready = 1'b0;
    end else begin
      case (state_r)
        IDLE:    in_ready = 1'b1;
        DONE:    in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept_s = in_valid & in_ready;

  // Control FSM with all outputs registered; a load overrides the DONE->IDLE exit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      word_r     <= 1'b0;
      rd_r       <= 5'd0;
      mac_sel    <= 8'd0;
      mac_src1   <= '0;
      mac_src2   <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= 5'd0;
    end else if (flush) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      mac_sel   <= 8'd0;
      out_valid <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        BUSY: begin
          if (cnt_r == '0) begin
            out_result <= res_ext_s;
            out_rd     <= rd_r;
            out_valid  <= 1'b1;
            mac_sel    <= 8'd0;
            state_r    <= DONE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          mac_sel   <= 8'd0;
          out_valid <= 1'b0;
        end
      endcase

      if (accept_s) begin
        state_r  <= BUSY;
        cnt_r    <= in_funct3[2] ? DIV_CNT : MUL_CNT;
        word_r   <= word_eff_s;
        rd_r     <= in_rd;
        mac_sel  <= sel_onehot(in_funct3);
        mac_src1 <= opnd1_s;
        mac_src2 <= opnd2_s;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl with a behavioural RV64M mac model.
module tb_mdu_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct3 = 3'd0;
  logic        in_word = 1'b0;
  logic [63:0] in_src1 = 64'd0;
  logic [63:0] in_src2 = 64'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [7:0]  mac_sel;
  logic [63:0] mac_src1;
  logic [63:0] mac_src2;
  logic [63:0] mac_result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic [4:0]  out_rd;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] res;
  } exp_t;
  exp_t sb[$];

  mdu_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct3  (in_funct3),
    .in_word    (in_word),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_rd      (in_rd),
    .mac_sel    (mac_sel),
    .mac_src1   (mac_src1),
    .mac_src2   (mac_src2),
    .mac_result (mac_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd)
  );

  always #5 clock = ~clock;

  // Behavioural mac: RV64M semantics on the 64-bit operands it is given
  logic [127:0] prod;
  always_comb begin
    prod = 128'd0;
    mac_result = 64'd0;
    if (mac_sel[0]) begin
      mac_result = mac_src1 * mac_src2;
    end else if (mac_sel[1]) begin
      prod = {{64{mac_src1[63]}}, mac_src1} * {{64{mac_src2[63]}}, mac_src2};
      mac_result = prod[127:64];
    end else if (mac_sel[2]) begin
      prod = {64'd0, mac_src1} * {64'd0, mac_src2};
      mac_result = prod[127:64];
    end else if (mac_sel[3]) begin
      prod = {{64{mac_src1[63]}}, mac_src1} * {64'd0, mac_src2};
      mac_result = prod[127:64];
    end else if (mac_sel[4]) begin
      if (mac_src2 == 64'd0) mac_result = {64{1'b1}};
      else if (mac_src1 == 64'h8000_0000_0000_0000 && mac_src2 == {64{1'b1}}) mac_result = mac_src1;
      else mac_result = $signed(mac_src1) / $signed(mac_src2);
    end else if (mac_sel[5]) begin
      if (mac_src2 == 64'd0) mac_result = {64{1'b1}};
      else mac_result = mac_src1 / mac_src2;
    end else if (mac_sel[6]) begin
      if (mac_src2 == 64'd0) mac_result = mac_src1;
      else if (mac_src1 == 64'h8000_0000_0000_0000 && mac_src2 == {64{1'b1}}) mac_result = 64'd0;
      else mac_result = $signed(mac_src1) % $signed(mac_src2);
    end else if (mac_sel[7]) begin
      if (mac_src2 == 64'd0) mac_result = mac_src1;
      else mac_result = mac_src1 % mac_src2;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every result handshake pops and compares the oldest expectation
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got rd=%0d res=%h expected none", out_rd, out_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", out_result, e.res);
        chk("sb_rd", {59'd0, out_rd}, {59'd0, e.rd});
      end
    end
  end

  // Called at the negedge after acceptance; counts edges until out_valid
  task automatic wait_done(input string name, input int lat);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
    end
    chk(name, 64'(cyc), 64'(lat));
  endtask

  task automatic drive(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd);
    in_valid  = 1'b1;
    in_funct3 = f3;
    in_word   = w;
    in_src1   = a;
    in_src2   = b;
    in_rd     = rd;
  endtask

  // Full op: entered and left at #1 after a posedge, out_ready held high
  task automatic do_op(input string name, input logic [2:0] f3, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                       input logic [63:0] exp, input logic [7:0] sel, input int lat);
    exp_t e;
    drive(f3, w, a, b, rd);
    @(negedge clock);
    chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    e.rd = rd;
    e.res = exp;
    sb.push_back(e);
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    chk({name, "_mac_sel"}, {56'd0, mac_sel}, {56'd0, sel});
    wait_done({name, "_latency"}, lat);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    repeat (2) @(negedge clock);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_mac_sel", {56'd0, mac_sel}, 64'd0);
    chk("rst_mac_src", mac_src1 | mac_src2, 64'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    do_op("mul",      3'b000, 1'b0, 64'd3, 64'd5, 5'd1, 64'd15, 8'h01, 2);
    do_op("mulw",     3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 8'h01, 2);
    do_op("divw_ovf", 3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd3, 64'hFFFF_FFFF_8000_0000, 8'h10, 4);
    do_op("divuw",    3'b101, 1'b1, 64'hFFFF_FFFF_0000_0007, 64'd2, 5'd4, 64'd3, 8'h20, 4);
    do_op("div_zero", 3'b100, 1'b0, 64'd100, 64'd0, 5'd5, {64{1'b1}}, 8'h10, 4);
    do_op("rem_zero", 3'b110, 1'b0, 64'h1234, 64'd0, 5'd6, 64'h1234, 8'h40, 4);
    do_op("div_neg",  3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFD, 8'h10, 4);
    do_op("divw_zero",3'b100, 1'b1, 64'd5, 64'd0, 5'd8, {64{1'b1}}, 8'h10, 4);
    do_op("remw",     3'b110, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2, 5'd9, {64{1'b1}}, 8'h40, 4);
    do_op("remuw",    3'b111, 1'b1, 64'hFFFF_FFFF_8000_0001, 64'h1_0000_0010, 5'd10, 64'd1, 8'h80, 4);
    do_op("mulhu",    3'b011, 1'b0, {64{1'b1}}, {64{1'b1}}, 5'd11, 64'hFFFF_FFFF_FFFF_FFFE, 8'h04, 2);
    do_op("mulhsu",   3'b010, 1'b0, {64{1'b1}}, {64{1'b1}}, 5'd12, {64{1'b1}}, 8'h08, 2);
    do_op("mulh",     3'b001, 1'b0, {64{1'b1}}, {64{1'b1}}, 5'd13, 64'd0, 8'h02, 2);
    do_op("mulhu_w",  3'b011, 1'b1, 64'h1_0000_0000, 64'h8000_0000_0000_0000, 5'd14, 64'h8000_0000, 8'h04, 2);

    // Back-pressure in DONE, then a back-to-back load on the release cycle
    out_ready = 1'b0;
    drive(3'b000, 1'b0, 64'd6, 64'd7, 5'd15);
    @(negedge clock);
    e.rd = 5'd15;
    e.res = 64'd42;
    sb.push_back(e);
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    wait_done("bp_latency", 2);
    repeat (3) begin
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_out_result", out_result, 64'd42);
      chk("bp_out_rd", {59'd0, out_rd}, 64'd15);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clock);
    end
    @(posedge clock);
    #1 out_ready = 1'b1;
    drive(3'b101, 1'b0, 64'd100, 64'd7, 5'd16);
    @(negedge clock);
    chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
    e.rd = 5'd16;
    e.res = 64'd14;
    sb.push_back(e);
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    chk("b2b_mac_sel", {56'd0, mac_sel}, 64'h20);
    chk("b2b_out_valid", {63'd0, out_valid}, 64'd0);
    wait_done("b2b_latency", 4);
    @(posedge clock);
    #1;

    // Flush in BUSY with a competing request
    drive(3'b100, 1'b0, 64'd50, 64'd5, 5'd17);
    @(negedge clock);
    @(posedge clock);
    #1 flush = 1'b1;
    drive(3'b000, 1'b0, 64'd2, 64'd2, 5'd18);
    @(negedge clock);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clock);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    chk("flush_mac_sel", {56'd0, mac_sel}, 64'd0);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_idle_ready", {63'd0, in_ready}, 64'd1);
    repeat (6) @(negedge clock);
    chk("flush_no_result", {63'd0, out_valid}, 64'd0);
    @(posedge clock);
    #1;

    // Async reset while BUSY
    drive(3'b100, 1'b0, 64'd9, 64'd3, 5'd19);
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    chk("pre_rst_mac_sel", {56'd0, mac_sel}, 64'h10);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_mac_sel", {56'd0, mac_sel}, 64'd0);
    chk("arst_mac_src", mac_src1 | mac_src2, 64'd0);
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_out", out_result | {59'd0, out_rd}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    do_op("post_rst", 3'b000, 1'b0, 64'd11, 64'd11, 5'd20, 64'd121, 8'h01, 2);

    repeat (3) @(posedge clock);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
